// File: rtl/tt_um_ternary_mac_if.sv
// Activation/result stream bundle for the ternary MAC.
// The master side feeds activations and consumes results.
interface tt_um_ternary_mac_if #(
  parameter int BIT_WIDTH_IN  = 8,
  parameter int BIT_WIDTH_OUT = 13,
  parameter int IDX_W         = 3
);
  logic                            in_valid;
  logic signed [BIT_WIDTH_IN-1:0]  in_data;
  logic                            in_ready;
  logic                            out_valid;
  logic signed [BIT_WIDTH_OUT-1:0] out_data;
  logic [IDX_W-1:0]                out_idx;
  logic                            out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/tt_um_ternary_mac.sv
// Ternary-weight vector MAC: streams activations through a live
// weight matrix, then drains saturated column sums one per transfer.
module tt_um_ternary_mac #(
  parameter int MAX_IN_LEN    = 16,
  parameter int MAX_OUT_LEN   = 8,
  parameter int BIT_WIDTH_IN  = 8,
  parameter int BIT_WIDTH_OUT = 13
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
  input  logic                               ui_load_done,
  input  logic                               ui_in_valid,
  input  logic signed [BIT_WIDTH_IN-1:0]     ui_in_data,
  output logic                               uo_in_ready,
  output logic                               uo_out_valid,
  output logic signed [BIT_WIDTH_OUT-1:0]    uo_out_data,
  output logic [$clog2(MAX_OUT_LEN)-1:0]     uo_out_idx,
  input  logic                               ui_out_ready
);

  localparam int ACC_W = BIT_WIDTH_IN + $clog2(MAX_IN_LEN) + 1;
  localparam int IW    = $clog2(MAX_IN_LEN);
  localparam int OW    = $clog2(MAX_OUT_LEN);
  localparam int RW    = 2 * MAX_OUT_LEN;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((2 ** (BIT_WIDTH_OUT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]           r_in_idx;
  logic [OW-1:0]           r_out_idx;
  logic signed [ACC_W-1:0] r_acc [MAX_OUT_LEN];

  logic                    w_load;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_in_last;
  logic                    w_out_last;
  logic                    w_clr;
  logic [RW-1:0]           w_row;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_sel;
  logic signed [BIT_WIDTH_OUT-1:0] w_sat;

  // a load pulse aborts any transfer that coincides with it
  assign w_load     = ena & ui_load_done;
  assign w_in_fire  = uo_in_ready & ui_in_valid & ~ui_load_done;
  assign w_out_fire = uo_out_valid & ui_out_ready & ~ui_load_done;
  assign w_in_last  = (r_in_idx == IW'(MAX_IN_LEN - 1));
  assign w_out_last = (r_out_idx == OW'(MAX_OUT_LEN - 1));
  assign w_clr      = w_load | (w_out_fire & w_out_last);

  assign w_row = ui_weights[int'(r_in_idx) * RW +: RW];
  assign w_x   = {{(ACC_W - BIT_WIDTH_IN){ui_in_data[BIT_WIDTH_IN-1]}},
                  ui_in_data};

  assign w_sel = r_acc[r_out_idx];

  always_comb begin
    w_sat = w_sel[BIT_WIDTH_OUT-1:0];
    if (w_sel > SAT_MAX) begin
      w_sat = SAT_MAX[BIT_WIDTH_OUT-1:0];
    end else if (w_sel < SAT_MIN) begin
      w_sat = SAT_MIN[BIT_WIDTH_OUT-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_load) w_next = ACCUM;
      end
      ACCUM: begin
        if (w_load) begin
          w_next = ACCUM;
        end else if (w_in_fire && w_in_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_load) begin
          w_next = ACCUM;
        end else if (w_out_fire && w_out_last) begin
          w_next = ACCUM;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    uo_in_ready  = 1'b0;
    uo_out_valid = 1'b0;
    uo_out_data  = '0;
    uo_out_idx   = '0;
    unique case (r_state)
      ACCUM: uo_in_ready = ena;
      DRAIN: begin
        uo_out_valid = ena;
        uo_out_data  = w_sat;
        uo_out_idx   = r_out_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_idx  <= '0;
      r_out_idx <= '0;
    end else if (ena) begin
      if (w_clr) begin
        r_in_idx  <= '0;
        r_out_idx <= '0;
      end else begin
        if (w_in_fire) begin
          r_in_idx <= w_in_last ? '0 : r_in_idx + 1'b1;
        end
        if (w_out_fire) begin
          r_out_idx <= r_out_idx + 1'b1;
        end
      end
    end
  end

  // codes 2'b00 and 2'b10 both mean zero weight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < MAX_OUT_LEN; j++) begin
        r_acc[j] <= '0;
      end
    end else if (ena) begin
      if (w_clr) begin
        for (int j = 0; j < MAX_OUT_LEN; j++) begin
          r_acc[j] <= '0;
        end
      end else if (w_in_fire) begin
        for (int j = 0; j < MAX_OUT_LEN; j++) begin
          case (w_row[2*j +: 2])
            2'b01:   r_acc[j] <= r_acc[j] + w_x;
            2'b11:   r_acc[j] <= r_acc[j] - w_x;
            default: r_acc[j] <= r_acc[j];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
// Randomised scoreboard bench for tt_um_ternary_mac, built with
// a 12-bit result so positive saturation is reachable.
module tb_tt_um_ternary_mac;
  localparam int NI   = 16;
  localparam int NO   = 8;
  localparam int BI   = 8;
  localparam int BO   = 12;
  localparam int OW   = 3;
  localparam int SMAX = (1 << (BO - 1)) - 1;
  localparam int SMIN = -(1 << (BO - 1));

  typedef struct {
    int idx;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic load = 1'b0;
  logic [2*NI*NO-1:0] wts = '0;

  tt_um_ternary_mac_if #(
    .BIT_WIDTH_IN(BI), .BIT_WIDTH_OUT(BO), .IDX_W(OW)
  ) vi ();

  tt_um_ternary_mac #(
    .MAX_IN_LEN(NI), .MAX_OUT_LEN(NO),
    .BIT_WIDTH_IN(BI), .BIT_WIDTH_OUT(BO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .ui_weights   (wts),
    .ui_load_done (load),
    .ui_in_valid  (vi.in_valid),
    .ui_in_data   (vi.in_data),
    .uo_in_ready  (vi.in_ready),
    .uo_out_valid (vi.out_valid),
    .uo_out_data  (vi.out_data),
    .uo_out_idx   (vi.out_idx),
    .ui_out_ready (vi.out_ready)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   wm [NI][NO];
  int   xv [NI];
  int   xs [NI];
  exp_t q [$];
  int   rmode = 0;
  bit   tog = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int s);
    if (s > SMAX) return SMAX;
    if (s < SMIN) return SMIN;
    return s;
  endfunction

  // 0: all +1, 1: even -1 / odd zero(10), 2: all -1, 3: random
  task automatic set_w(input int mode);
    logic [1:0] c;
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < NO; j++) begin
        case (mode)
          0: c = 2'b01;
          1: c = (j % 2 == 0) ? 2'b11 : 2'b10;
          2: c = 2'b11;
          default: c = 2'($urandom_range(0, 3));
        endcase
        wts[i*2*NO + 2*j +: 2] = c;
        wm[i][j] = (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
      end
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push_exp();
    int s;
    for (int j = 0; j < NO; j++) begin
      s = 0;
      for (int i = 0; i < NI; i++) s += wm[i][j] * xv[i];
      q.push_back('{idx: j, data: sat(s)});
    end
  endtask

  task automatic send(input int x);
    int n;
    n = 0;
    vi.in_valid = 1'b1;
    vi.in_data  = BI'(x);
    while (!vi.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_accept_timeout", int'(vi.in_ready), 1);
    @(negedge clk);
    vi.in_valid = 1'b0;
  endtask

  task automatic feed(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      xv[i] = xs[i];
      if (i == NI - 1) push_exp();
      send(xs[i]);
    end
    if (hi == NI - 1) chk("first_valid_latency", int'(vi.out_valid), 1);
  endtask

  task automatic rand_xs();
    for (int i = 0; i < NI; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    vi.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (rmode)
        0:       vi.out_ready = 1'b1;
        1:       begin tog = ~tog; vi.out_ready = tog; end
        2:       vi.out_ready = 1'($urandom_range(0, 1));
        default: vi.out_ready = 1'b0;
      endcase
      if (!rst_n) begin
        q.delete();
      end else begin
        if (vi.out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out", int'(vi.out_valid), 0);
          end else begin
            chk("out_idx", int'(vi.out_idx), q[0].idx);
            chk("out_data", int'(vi.out_data), q[0].data);
            if (vi.out_ready && !load) void'(q.pop_front());
          end
        end
        if (load && ena) q.delete();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vi.in_valid = 1'b0;
    vi.in_data  = '0;
    ena = 1'b1;
    #3;
    chk("rst_in_ready", int'(vi.in_ready), 0);
    chk("rst_out_valid", int'(vi.out_valid), 0);
    chk("rst_out_data", int'(vi.out_data), 0);
    chk("rst_out_idx", int'(vi.out_idx), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vi.in_valid = 1'b1;
    @(negedge clk);
    repeat (3) begin
      chk("idle_in_ready", int'(vi.in_ready), 0);
      @(negedge clk);
    end
    vi.in_valid = 1'b0;

    rmode = 0;
    set_w(0);
    pulse_load();
    for (int i = 0; i < NI; i++) xs[i] = i + 1;
    feed(0, NI - 1, 1'b0);
    wait_empty();

    set_w(1);
    pulse_load();
    for (int i = 0; i < NI; i++) xs[i] = 5;
    feed(0, NI - 1, 1'b0);
    wait_empty();

    set_w(2);
    pulse_load();
    for (int i = 0; i < NI; i++) xs[i] = -128;
    feed(0, NI - 1, 1'b0);
    wait_empty();

    rmode = 1;
    set_w(3);
    pulse_load();
    repeat (3) begin
      rand_xs();
      feed(0, NI - 1, 1'b1);
    end
    wait_empty();

    rmode = 2;
    repeat (3) begin
      rand_xs();
      feed(0, NI - 1, 1'b0);
    end
    wait_empty();

    rand_xs();
    feed(0, 6, 1'b0);
    set_w(3);
    pulse_load();
    rand_xs();
    feed(0, NI - 1, 1'b1);
    wait_empty();

    rmode = 0;
    rand_xs();
    feed(0, 4, 1'b0);
    ena = 1'b0;
    vi.in_valid = 1'b1;
    vi.in_data  = 8'sd7;
    @(negedge clk);
    repeat (3) begin
      chk("frozen_in_ready", int'(vi.in_ready), 0);
      @(negedge clk);
    end
    vi.in_valid = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    rmode = 3;
    feed(5, NI - 1, 1'b0);
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    repeat (2) begin
      chk("frozen_out_valid", int'(vi.out_valid), 0);
      @(negedge clk);
    end
    ena = 1'b1;
    rmode = 0;
    @(negedge clk);
    wait_empty();

    rmode = 3;
    rand_xs();
    feed(0, NI - 1, 1'b0);
    repeat (3) @(negedge clk);
    set_w(3);
    pulse_load();
    rmode = 2;
    rand_xs();
    feed(0, NI - 1, 1'b0);
    wait_empty();

    rmode = 1;
    rand_xs();
    feed(0, NI - 1, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", int'(vi.in_ready), 0);
    chk("async_rst_out_valid", int'(vi.out_valid), 0);
    chk("async_rst_out_data", int'(vi.out_data), 0);
    chk("async_rst_out_idx", int'(vi.out_idx), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vi.in_valid = 1'b1;
    @(negedge clk);
    repeat (4) begin
      chk("post_rst_in_ready", int'(vi.in_ready), 0);
      @(negedge clk);
    end
    vi.in_valid = 1'b0;
    rmode = 2;
    set_w(3);
    pulse_load();
    rand_xs();
    feed(0, NI - 1, 1'b1);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tt_um_ternary_mac.md
TT_UM_TERNARY_MAC -- requirements
Module: tt_um_ternary_mac

Interface
REQ-001 SHALL have parameter MAX_IN_LEN, default 16: number of input activations per vector (weight rows).
REQ-002 SHALL have parameter MAX_OUT_LEN, default 8: number of outputs per vector (weight columns).
REQ-003 SHALL have parameter BIT_WIDTH_IN, default 8: signed activation width.
REQ-004 SHALL have parameter BIT_WIDTH_OUT, default 13: signed result width, allowed range 2..ACC_W.
REQ-005 SHALL define localparam ACC_W = BIT_WIDTH_IN + $clog2(MAX_IN_LEN) + 1 as the internal accumulator width.
REQ-006 SHALL have port clk, input, 1: single clock; one clock only, all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port ena, input, 1: block enable.
REQ-009 SHALL have port ui_weights, input, 2*MAX_IN_LEN*MAX_OUT_LEN: packed ternary weights from the weight loader.
REQ-010 SHALL have port ui_load_done, input, 1: loader completion pulse; ui_weights is stable from the following cycle.
REQ-011 SHALL have port ui_in_valid, input, 1: activation valid.
REQ-012 SHALL have port ui_in_data, input, BIT_WIDTH_IN: signed activation.
REQ-013 SHALL have port uo_in_ready, output, 1: activation accepted this cycle when high with ui_in_valid.
REQ-014 SHALL have port uo_out_valid, output, 1: result valid.
REQ-015 SHALL have port uo_out_data, output, BIT_WIDTH_OUT: signed saturated result.
REQ-016 SHALL have port uo_out_idx, output, $clog2(MAX_OUT_LEN): column index of uo_out_data.
REQ-017 SHALL have port ui_out_ready, input, 1: downstream accepts result when high with uo_out_valid.

Function
REQ-018 Weight (i,j) SHALL be ui_weights[i*2*MAX_OUT_LEN + 2*j +: 2]; 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0.
REQ-019 SHALL implement states IDLE, ACCUM, DRAIN; weights are read live, never copied.
REQ-020 IDLE -> ACCUM on the edge after ui_load_done=1 with ena=1; on entering ACCUM all MAX_OUT_LEN accumulators and in_idx SHALL be zero.
REQ-021 uo_in_ready SHALL equal (state==ACCUM && ena).
REQ-022 Per accepted activation x at row in_idx: acc[j] <= acc[j] + w(in_idx,j)*x for every j in one cycle (+x, -x or hold), sign-extended to ACC_W; in_idx increments.
REQ-023 Acceptance at in_idx == MAX_IN_LEN-1 SHALL move to DRAIN next cycle with out_idx=0; no wrap of in_idx within ACCUM.
REQ-024 In DRAIN uo_out_valid=ena; uo_out_idx=out_idx; uo_out_data=sat(acc[out_idx]), clamped to [-2^(BIT_WIDTH_OUT-1), 2^(BIT_WIDTH_OUT-1)-1].
REQ-025 uo_out_valid && ui_out_ready SHALL advance out_idx; transfer at out_idx==MAX_OUT_LEN-1 returns to ACCUM (accumulators cleared, weights reused); data/idx SHALL hold while ready low.
REQ-026 ena=0 SHALL freeze all state; uo_in_ready and uo_out_valid low.
REQ-027 ui_load_done=1 with ena=1 in ACCUM or DRAIN SHALL abort: next state ACCUM, accumulators, in_idx, out_idx cleared, no further results of the aborted vector emitted; abort overrides a simultaneous input or output transfer.
REQ-028 Result latency: first uo_out_valid the cycle after the last activation is accepted.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, accumulators, in_idx, out_idx to 0, uo_in_ready=0, uo_out_valid=0, uo_out_data=0, uo_out_idx=0.
REQ-030 After reset, no activation SHALL be accepted until a ui_load_done pulse.

Verification
REQ-031 Reset: assert rst_n=0 mid-DRAIN, no clock edge -> all outputs 0 immediately; uo_in_ready stays 0 until ui_load_done.
REQ-032 All weights 2'b01, activations 1..16 streamed back-to-back -> 8 results of 136, idx 0..7, first valid one cycle after 16th accept.
REQ-033 Column j weights: j even 2'b11, j odd 2'b10, all activations 5 -> even columns -80, odd columns 0.
REQ-034 BIT_WIDTH_OUT=12, all weights 2'b11, all activations -128 -> 2048 saturates to 2047 on every output.
REQ-035 Backpressure: ui_out_ready toggled 1010..., in_valid gaps -> each result held stable until accepted, none lost or duplicated, next vector accumulates from zero.
REQ-036 ui_load_done pulse after 7 accepted activations -> accumulators cleared, next 16 activations produce results of the new vector only.
